// File: rtl/pn_frame_pkg.sv
// Shared types and default constants for the PN7 framed baseband bit source.
package pn_frame_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   localparam int unsigned DEF_LFSR_W      = 7;
   localparam logic [6:0]  DEF_TAPS        = 7'h60;      // x^7 + x^6 + 1
   localparam logic [6:0]  DEF_SEED        = 7'h7F;
   localparam int unsigned DEF_SYNC_LEN    = 7;
   localparam logic [6:0]  DEF_SYNC_WORD   = 7'b1110010;
   localparam int unsigned DEF_PAYLOAD_LEN = 24;

   // Index counter covers both the sync word and payloads of up to 255 bits.
   localparam int unsigned IDX_W = 8;

endpackage

// File: rtl/lfsr_prbs7.sv
// Fibonacci LFSR PN source: MSB is the current bit, advances one step per adv.
// An all-zero state is recovered by reloading the seed while emitting 0.
module lfsr_prbs7
   import pn_frame_pkg::*;
#(
   parameter int unsigned       LFSR_W = DEF_LFSR_W,
   parameter logic [LFSR_W-1:0] TAPS   = DEF_TAPS,
   parameter logic [LFSR_W-1:0] SEED   = DEF_SEED
) (
   input  logic clk,
   input  logic rst,
   input  logic adv,
   output logic out_bit
);

   logic [LFSR_W-1:0] lfsr;
   logic              lockup;

   assign lockup  = (lfsr == '0);
   assign out_bit = lockup ? 1'b0 : lfsr[LFSR_W-1];

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (adv) begin
         if (lockup) lfsr <= SEED;
         else        lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
      end
   end

endmodule

// File: rtl/pn_frame_gen.sv
// Framed baseband source: sync word then PN7 payload, one bit per rising
// edge of the in-domain symbol clock, with optional differential encoding.
module pn_frame_gen
   import pn_frame_pkg::*;
#(
   parameter int unsigned         LFSR_W      = DEF_LFSR_W,
   parameter logic [LFSR_W-1:0]   TAPS        = DEF_TAPS,
   parameter logic [LFSR_W-1:0]   SEED        = DEF_SEED,
   parameter int unsigned         SYNC_LEN    = DEF_SYNC_LEN,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD   = DEF_SYNC_WORD,
   parameter int unsigned         PAYLOAD_LEN = DEF_PAYLOAD_LEN,
   parameter bit                  DIFF_EN     = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       sym_clk,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       in_sync,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam logic [IDX_W-1:0] SYNC_LAST    = IDX_W'(SYNC_LEN - 1);
   localparam logic [IDX_W-1:0] PAYLOAD_LAST = IDX_W'(PAYLOAD_LEN - 1);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic                sym_d;
   logic                tick;
   logic                adv;
   logic                pn_bit;
   logic [SYNC_LEN-1:0] sync_shift;
   logic                sync_bit;

   assign tick = sym_clk & ~sym_d;

   // Sync bits leave MSB first: shifting left by idx brings bit idx to the top.
   assign sync_shift = SYNC_WORD << idx;
   assign sync_bit   = sync_shift[SYNC_LEN-1];

   // The LFSR only steps on ticks that actually emit a payload bit.
   assign adv = (state == PAYLOAD) && en && tick;

   lfsr_prbs7 #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .SEED   (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .out_bit (pn_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sym_d resets high so a sym_clk already high at release is not an edge.
         sym_d       <= 1'b1;
         state       <= IDLE;
         idx         <= '0;
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         in_sync     <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         sym_d       <= sym_clk;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;

         case (state)
            IDLE: begin
               if (en) begin
                  state <= SYNC;
                  idx   <= '0;
               end
            end

            SYNC: begin
               if (!en) begin
                  state <= IDLE;
               end else if (tick) begin
                  bit_out     <= sync_bit;
                  in_sync     <= 1'b1;
                  bit_valid   <= 1'b1;
                  frame_start <= (idx == '0);
                  if (idx == SYNC_LAST) begin
                     state <= PAYLOAD;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end

            PAYLOAD: begin
               if (!en) begin
                  state <= IDLE;
               end else if (tick) begin
                  // Differential reference chains from the last sync bit.
                  bit_out   <= DIFF_EN ? (pn_bit ^ bit_out) : pn_bit;
                  in_sync   <= 1'b0;
                  bit_valid <= 1'b1;
                  if (idx == PAYLOAD_LAST) begin
                     state     <= SYNC;
                     idx       <= '0;
                     frame_cnt <= frame_cnt + 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pn_frame_gen.sv
// Bench for pn_frame_gen: directed vector table, long/random runs, and a
// cycle-level reference model built from the frame rules and the PN recurrence.
module tb_pn_frame_gen;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       en      = 1'b0;
   logic       sym_clk = 1'b1;

   logic       bit_out0, bit_valid0, in_sync0, frame_start0;
   logic       bit_out1, bit_valid1, in_sync1, frame_start1;
   logic [7:0] frame_cnt0, frame_cnt1;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pn_frame_gen #(.DIFF_EN(1'b0)) dut0 (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sym_clk     (sym_clk),
      .bit_out     (bit_out0),
      .bit_valid   (bit_valid0),
      .in_sync     (in_sync0),
      .frame_start (frame_start0),
      .frame_cnt   (frame_cnt0)
   );

   pn_frame_gen #(.DIFF_EN(1'b1)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sym_clk     (sym_clk),
      .bit_out     (bit_out1),
      .bit_valid   (bit_valid1),
      .in_sync     (in_sync1),
      .frame_start (frame_start1),
      .frame_cnt   (frame_cnt1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   localparam int SYNC_N  = 7;
   localparam int PAY_N   = 24;
   localparam int FRAME_N = SYNC_N + PAY_N;

   logic [6:0] sync_word = 7'b1110010;
   logic [6:0] seed_v    = 7'h7F;
   logic       pn [127];

   logic m_active, m_bit0, m_bit1, m_valid, m_sync, m_fs, m_symp;
   int   m_pos, m_pn, m_fc;

   // PN7 output stream: first 7 bits are the seed MSB first, then o[n+7] = o[n] ^ o[n+1].
   task automatic build_pn();
      for (int k = 0; k < 7; k++) pn[k] = seed_v[3'(6 - k)];
      for (int k = 7; k < 127; k++) pn[k] = pn[k-7] ^ pn[k-6];
   endtask

   task automatic model_step(input logic r, input logic e, input logic s);
      logic tk, raw;
      if (r) begin
         m_active = 1'b0; m_pos = 0; m_pn = 0; m_fc = 0;
         m_bit0 = 1'b0; m_bit1 = 1'b0; m_valid = 1'b0; m_sync = 1'b0; m_fs = 1'b0;
         m_symp = 1'b1;
         return;
      end
      m_valid = 1'b0;
      m_fs    = 1'b0;
      tk      = s & ~m_symp;
      m_symp  = s;
      if (!m_active) begin
         if (e) begin m_active = 1'b1; m_pos = 0; end
      end else if (!e) begin
         m_active = 1'b0;
      end else if (tk) begin
         m_valid = 1'b1;
         if (m_pos < SYNC_N) begin
            m_bit0 = sync_word[3'(SYNC_N - 1 - m_pos)];
            m_bit1 = m_bit0;
            m_sync = 1'b1;
            m_fs   = (m_pos == 0);
         end else begin
            raw    = pn[m_pn];
            m_pn   = (m_pn + 1) % 127;
            m_bit0 = raw;
            m_bit1 = m_bit1 ^ raw;
            m_sync = 1'b0;
         end
         m_pos++;
         if (m_pos == FRAME_N) begin
            m_pos = 0;
            m_fc  = (m_fc + 1) % 256;
         end
      end
   endtask

   initial begin
      build_pn();
      forever begin
         @(posedge clk);
         model_step(rst, en, sym_clk);
         #1;
         check("stream_d0", 32'({bit_out0, bit_valid0, in_sync0, frame_start0, frame_cnt0}),
               32'({m_bit0, m_valid, m_sync, m_fs, 8'(m_fc)}));
         check("stream_d1", 32'({bit_out1, bit_valid1, in_sync1, frame_start1, frame_cnt1}),
               32'({m_bit1, m_valid, m_sync, m_fs, 8'(m_fc)}));
      end
   end

   // Payload bits of the non-differential stream, for the period check.
   logic collect = 1'b0;
   logic pay_q [$];
   always @(negedge clk) begin
      if (collect && bit_valid0 && !in_sync0 && pay_q.size() < 254) pay_q.push_back(bit_out0);
   end

   // ---------------- directed table ----------------
   typedef struct {
      logic en;
      logic b0;
      logic b1;
      logic sync;
      logic fs;
   } vec_t;

   vec_t tbl [15];

   task automatic do_tick(input int hi, input int lo);
      sym_clk = 1'b1;
      repeat (hi) @(negedge clk);
      sym_clk = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // Period-8 symbol clock; each bit must appear one clk after the rise, one clk wide.
   task automatic apply_table(input string tag);
      for (int i = 0; i < 15; i++) begin
         en      = tbl[i].en;
         sym_clk = 1'b1;
         @(negedge clk);
         check($sformatf("%s_vec%0d", tag, i),
               32'({bit_valid0, bit_valid1, bit_out0, bit_out1, in_sync0, frame_start0}),
               32'({2'b11, tbl[i].b0, tbl[i].b1, tbl[i].sync, tbl[i].fs}));
         @(negedge clk);
         check($sformatf("%s_width%0d", tag, i), 32'({bit_valid0, frame_start0}), 32'd0);
         repeat (2) @(negedge clk);
         sym_clk = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      logic [14:0] e0, e1, sy;
      logic        saw;
      int          fc_hold;

      e0 = 15'b1110010_11111110;
      e1 = 15'b1110010_10101011;
      sy = 15'b1111111_00000000;
      for (int i = 0; i < 15; i++) begin
         tbl[i].en   = 1'b1;
         tbl[i].b0   = e0[4'(14 - i)];
         tbl[i].b1   = e1[4'(14 - i)];
         tbl[i].sync = sy[4'(14 - i)];
         tbl[i].fs   = (i == 0);
      end

      // Reset with sym_clk high, then idle with en low.
      rst = 1'b1; sym_clk = 1'b1; en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (8) begin
            @(negedge clk);
            if (bit_valid0 || bit_valid1) saw = 1'b1;
         end
         sym_clk = ~sym_clk;
      end
      check("idle_no_valid", 32'(saw), 32'd0);
      check("idle_outputs", 32'({bit_out0, in_sync0, frame_start0, frame_cnt0, bit_out1}), 32'd0);

      // First frame: sync word then first payload bits, both encodings.
      rst = 1'b1; sym_clk = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; en = 1'b1; collect = 1'b1;
      repeat (2) @(negedge clk);
      apply_table("first");

      // 256 frames with a randomised symbol-clock duty cycle.
      for (int t = 15; t < 256 * FRAME_N; t++) begin
         do_tick($urandom_range(2, 1), $urandom_range(2, 1));
         if (t + 1 == 256 * FRAME_N - 1) check("fc_255", 32'(frame_cnt0), 32'd255);
      end
      check("fc_wrap0", 32'(frame_cnt0), 32'd0);
      check("fc_wrap1", 32'(frame_cnt1), 32'd0);
      collect = 1'b0;
      begin
         int bad;
         bad = (pay_q.size() == 254) ? 0 : 1000;
         for (int i = 0; i < 127 && i + 127 < pay_q.size(); i++)
            if (pay_q[i] !== pay_q[i+127]) bad++;
         check("pn_period_127", 32'(bad), 32'd0);
      end

      // en dropped for 3 clk mid-payload with a coincident tick.
      for (int i = 0; i < 10; i++) do_tick(2, 2);
      fc_hold = int'(frame_cnt0);
      en = 1'b0; sym_clk = 1'b1;
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bit_valid0 || bit_valid1) saw = 1'b1;
      end
      check("drop_no_strobe", 32'(saw), 32'd0);
      en = 1'b1; sym_clk = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < SYNC_N; i++) begin
         sym_clk = 1'b1;
         @(negedge clk);
         check($sformatf("resync%0d", i), 32'({bit_valid0, in_sync0, frame_start0, bit_out0}),
               32'({2'b11, (i == 0), sync_word[3'(6 - i)]}));
         @(negedge clk);
         sym_clk = 1'b0;
         repeat (2) @(negedge clk);
      end
      sym_clk = 1'b1;
      @(negedge clk);
      check("resume_pn", 32'({bit_valid0, in_sync0, bit_out0}),
            32'({2'b10, pn[(256 * PAY_N + 3) % 127]}));
      check("drop_fc_held", 32'(frame_cnt0), 32'(fc_hold));
      @(negedge clk);
      sym_clk = 1'b0;
      repeat (2) @(negedge clk);

      // Random enable and symbol-clock activity.
      for (int i = 0; i < 400; i++) begin
         en      = ($urandom_range(19, 0) != 0);
         sym_clk = ~sym_clk;
         repeat ($urandom_range(3, 1)) @(negedge clk);
      end

      // Restart a frame, then reset at sync index 4 with a coincident tick.
      en = 1'b0; sym_clk = 1'b0;
      @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) do_tick(2, 2);
      check("pre_rst_sync", 32'(in_sync0), 32'd1);
      rst = 1'b1; sym_clk = 1'b1;
      @(negedge clk);
      check("rst_vals0", 32'({bit_out0, bit_valid0, in_sync0, frame_start0, frame_cnt0}), 32'd0);
      check("rst_vals1", 32'({bit_out1, bit_valid1, in_sync1, frame_start1, frame_cnt1}), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("no_tick_at_release", 32'(bit_valid0), 32'd0);
      sym_clk = 1'b0;
      repeat (2) @(negedge clk);
      apply_table("after_rst");

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
